// File: rtl/md_cycle_sequencer.sv
// Step sequencer for multicycle multiply/divide: a start loads the op's length, then a binary
// step index walks 0..LEN-1 once per enabled cycle, followed by a one-cycle done strobe.
module md_cycle_sequencer #(
  parameter int CNT_W       = 6,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_enable,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             op_is_div,
  output logic [CNT_W-1:0] step,
  output logic             first,
  output logic             last,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             op_is_div_q, op_is_div_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] last_step;

  assign last_step = op_is_div_q ? DIV_LAST : MULT_LAST;

  // Everything holds unless ctrl_enable is high; cancel beats a dual start, which beats a single start.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    op_is_div_d = op_is_div_q;
    err_d       = err_q;
    if (ctrl_enable) begin
      err_d = 1'b0;
      if (cancel) begin
        state_d = ST_IDLE;
        step_d  = '0;
      end else if (start_mult && start_div) begin
        err_d = 1'b1;
      end else if (start_mult || start_div) begin
        state_d     = ST_RUN;
        step_d      = '0;
        op_is_div_d = start_div;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (step_q == last_step) begin
              state_d = ST_DONE;
              step_d  = '0;
            end else begin
              step_d = step_q + CNT_W'(1);
            end
          end
          ST_DONE: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      op_is_div_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      op_is_div_q <= op_is_div_d;
      err_q       <= err_d;
    end
  end

  // Outputs decode registered state only, so nothing combinational reaches them from the inputs.
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign op_is_div = op_is_div_q;
  assign step      = step_q;
  assign first     = busy && (step_q == '0);
  assign last      = busy && (step_q == last_step);
  assign err       = err_q;

endmodule
